// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: operand request and product response handshakes for the two clients
interface mul_arbiter_if #(parameter int WIDTH = 4);
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic res0_valid, res1_valid, res0_ready, res1_ready;
    logic [2*WIDTH-1:0] res_pro;
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res0_ready, res1_ready,
        output req0_ready, req1_ready, res0_valid, res1_valid, res_pro
    );
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res0_ready, res1_ready,
        input  req0_ready, req1_ready, res0_valid, res1_valid, res_pro
    );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one external multiplier between two requesters (round-robin,
// or fixed priority to req0 when MUL_ARB_FIXED_PRIO_EN is defined).
module mul_arbiter #(parameter int WIDTH = 4) (
    input  logic               clk,
    input  logic               rst,
    mul_arbiter_if.slave       bus,
    output logic [WIDTH-1:0]   mul_in1,
    output logic [WIDTH-1:0]   mul_in2,
    input  logic [2*WIDTH-1:0] mul_pro
);
`ifdef MUL_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic last, gnt, grant, fire;
    logic [WIDTH-1:0] op_a, op_b;
    logic [2*WIDTH-1:0] pro_q;
    logic res0_q, res1_q;
    // grant=1 selects req1; it only loses to req0 on contention when req0 is due
    assign grant = bus.req1_valid && (!bus.req0_valid || (!last && !FIXED));
    assign fire = state == IDLE && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = state == IDLE && bus.req0_valid && !grant;
    assign bus.req1_ready = state == IDLE && grant;
    assign bus.res0_valid = res0_q;
    assign bus.res1_valid = res1_q;
    assign bus.res_pro = pro_q;
    assign mul_in1 = op_a;
    assign mul_in2 = op_b;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last <= 1'b1;
            gnt <= 1'b0;
            op_a <= '0;
            op_b <= '0;
            pro_q <= '0;
            res0_q <= 1'b0;
            res1_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    op_a <= grant ? bus.req1_a : bus.req0_a;
                    op_b <= grant ? bus.req1_b : bus.req0_b;
                    gnt <= grant;
                    last <= grant;
                    state <= EXEC;
                end
                EXEC: begin
                    pro_q <= mul_pro;
                    res0_q <= !gnt;
                    res1_q <= gnt;
                    state <= RESP;
                end
                RESP: if (gnt ? bus.res1_ready : bus.res0_ready) begin
                    res0_q <= 1'b0;
                    res1_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed checks of arbitration, latency, backpressure and reset
module tb_mul_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] mul_in1, mul_in2;
    logic [7:0] mul_pro;
    int checks = 0;
    int errors = 0;
    mul_arbiter_if #(.WIDTH(4)) bus();
    mul_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_pro(mul_pro));
    assign mul_pro = {4'h0, mul_in1} * {4'h0, mul_in2};
    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // runs one transaction for whichever requester gets granted; the granted valid is dropped
    task automatic serve(output logic [1:0] who, output logic [7:0] pro, output int lat);
        int n;
        n = 0;
        lat = 0;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && n < 8) begin
            step();
            n++;
        end
        who = {bus.req1_ready, bus.req0_ready};
        step();
        if (who[0]) bus.req0_valid = 1'b0;
        if (who[1]) bus.req1_valid = 1'b0;
        lat = 1;
        while (!(bus.res0_valid || bus.res1_valid) && lat < 8) begin
            step();
            lat++;
        end
        pro = bus.res_pro;
    endtask

    task automatic test_reset;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.res0_ready = 1; bus.res1_ready = 1;
        rst = 1'b1;
        step();
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b exp 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b exp 0", bus.req1_ready); end
        checks++; if ({bus.res0_valid, bus.res1_valid} !== 2'b00) begin errors++; $display("FAIL reset_res_valid got %b exp 00", {bus.res0_valid, bus.res1_valid}); end
        checks++; if (bus.res_pro !== 8'h00) begin errors++; $display("FAIL reset_res_pro got %h exp 00", bus.res_pro); end
        checks++; if ({mul_in1, mul_in2} !== 8'h00) begin errors++; $display("FAIL reset_mul_in got %h exp 00", {mul_in1, mul_in2}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single;
        bus.req0_a = 4'h3; bus.req0_b = 4'h7; bus.req0_valid = 1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got %b exp 1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready got %b exp 0", bus.req1_ready); end
        step();
        bus.req0_valid = 0;
        bus.req0_a = 4'h0; bus.req0_b = 4'h0;
        #1;
        checks++; if (bus.res0_valid !== 1'b0) begin errors++; $display("FAIL single_exec_res0_valid got %b exp 0", bus.res0_valid); end
        checks++; if ({mul_in1, mul_in2} !== 8'h37) begin errors++; $display("FAIL single_mul_in got %h exp 37", {mul_in1, mul_in2}); end
        bus.req1_valid = 1;
        #1;
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_exec_req1_ready got %b exp 0", bus.req1_ready); end
        bus.req1_valid = 0;
        step();
        checks++; if (bus.res0_valid !== 1'b1) begin errors++; $display("FAIL single_res0_valid got %b exp 1", bus.res0_valid); end
        checks++; if (bus.res_pro !== 8'h15) begin errors++; $display("FAIL single_res_pro got %h exp 15", bus.res_pro); end
        checks++; if (bus.res1_valid !== 1'b0) begin errors++; $display("FAIL single_res1_valid got %b exp 0", bus.res1_valid); end
        step();
        checks++; if (bus.res0_valid !== 1'b0) begin errors++; $display("FAIL single_res0_clear got %b exp 0", bus.res0_valid); end
    endtask

    task automatic test_contention;
        logic [1:0] who;
        logic [7:0] pro;
        int lat;
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            bus.req0_a = 4'h3; bus.req0_b = 4'h5; bus.req0_valid = 1;
            bus.req1_a = 4'hE; bus.req1_b = 4'hB; bus.req1_valid = 1;
            serve(who, pro, lat);
            checks++; if (who !== 2'b01) begin errors++; $display("FAIL contention%0d_first_grant got %b exp 01", r, who); end
            checks++; if (pro !== 8'h0F) begin errors++; $display("FAIL contention%0d_first_pro got %h exp 0f", r, pro); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL contention%0d_latency got %0d exp 2", r, lat); end
            checks++; if (bus.res1_valid !== 1'b0) begin errors++; $display("FAIL contention%0d_res1_valid got %b exp 0", r, bus.res1_valid); end
            step();
            serve(who, pro, lat);
            checks++; if (who !== 2'b10) begin errors++; $display("FAIL contention%0d_second_grant got %b exp 10", r, who); end
            checks++; if (pro !== 8'h9A) begin errors++; $display("FAIL contention%0d_second_pro got %h exp 9a", r, pro); end
            checks++; if (bus.res1_valid !== 1'b1) begin errors++; $display("FAIL contention%0d_res1_valid got %b exp 1", r, bus.res1_valid); end
            step();
        end
    endtask

    task automatic test_alternate;
        logic [1:0] who;
        logic [1:0] exp_who;
        logic [7:0] pro;
        int lat;
        pulse_reset();
        bus.req0_a = 4'h2; bus.req0_b = 4'h2;
        bus.req1_a = 4'h3; bus.req1_b = 4'h3;
        for (int i = 0; i < 4; i++) begin
            bus.req0_valid = 1; bus.req1_valid = 1;
            serve(who, pro, lat);
`ifdef MUL_ARB_FIXED_PRIO_EN
            exp_who = 2'b01;
`else
            exp_who = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            checks++; if (who !== exp_who) begin errors++; $display("FAIL alternate%0d_grant got %b exp %b", i, who, exp_who); end
            checks++; if (pro !== (exp_who[0] ? 8'h04 : 8'h09)) begin errors++; $display("FAIL alternate%0d_pro got %h exp %h", i, pro, exp_who[0] ? 8'h04 : 8'h09); end
            step();
        end
        bus.req0_valid = 0; bus.req1_valid = 1;
        serve(who, pro, lat);
        checks++; if (who !== 2'b10) begin errors++; $display("FAIL alternate_req1_only_grant got %b exp 10", who); end
        bus.req0_valid = 0; bus.req1_valid = 0;
        step();
    endtask

    task automatic test_backpressure;
        logic [1:0] who;
        logic [7:0] pro;
        int lat;
        bus.res1_ready = 0;
        bus.req1_a = 4'hC; bus.req1_b = 4'hD; bus.req1_valid = 1;
        serve(who, pro, lat);
        checks++; if (who !== 2'b10) begin errors++; $display("FAIL bp_grant got %b exp 10", who); end
        checks++; if (pro !== 8'h9C) begin errors++; $display("FAIL bp_pro got %h exp 9c", pro); end
        bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.req0_valid = 1;
        bus.res0_ready = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({bus.res1_valid, bus.res_pro} !== 9'h19C) begin errors++; $display("FAIL bp_hold%0d got %b/%h exp 1/9c", i, bus.res1_valid, bus.res_pro); end
            checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", i, {bus.req0_ready, bus.req1_ready}); end
        end
        bus.res1_ready = 1;
        step();
        checks++; if (bus.res1_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", bus.res1_valid); end
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b exp 1", bus.req0_ready); end
        bus.req0_valid = 0;
        #1;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL bp_drop_ready got %b exp 0", bus.req0_ready); end
        step();
    endtask

    task automatic test_boundaries;
        logic [15:0] vec [3];
        logic [1:0] who;
        logic [7:0] pro;
        int lat;
        vec[0] = 16'h0500; vec[1] = 16'hFFE1; vec[2] = 16'h1D0D;
        for (int i = 0; i < 3; i++) begin
            bus.req0_a = vec[i][15:12]; bus.req0_b = vec[i][11:8]; bus.req0_valid = 1;
            serve(who, pro, lat);
            checks++; if (pro !== vec[i][7:0]) begin errors++; $display("FAIL boundary%0d_pro got %h exp %h", i, pro, vec[i][7:0]); end
            step();
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] who;
        logic [7:0] pro;
        int lat;
        bus.req0_a = 4'h6; bus.req0_b = 4'h4; bus.req0_valid = 1;
        serve(who, pro, lat);
        bus.req1_a = 4'h5; bus.req1_b = 4'h5; bus.req1_valid = 1;
        #1;
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL b2b_resp_ready got %b exp 0", bus.req1_ready); end
        step();
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL b2b_next_ready got %b exp 1", bus.req1_ready); end
        serve(who, pro, lat);
        checks++; if ({who, pro} !== {2'b10, 8'h19}) begin errors++; $display("FAIL b2b_second got %b/%h exp 10/19", who, pro); end
        step();
    endtask

    task automatic test_reset_mid_op;
        bus.req1_a = 4'h2; bus.req1_b = 4'h3; bus.req1_valid = 1;
        step();
        bus.req1_valid = 0;
        #1;
        checks++; if ({mul_in1, mul_in2} !== 8'h23) begin errors++; $display("FAIL midrst_exec_in got %h exp 23", {mul_in1, mul_in2}); end
        rst = 1'b1;
        #1;
        checks++; if ({mul_in1, mul_in2} !== 8'h00) begin errors++; $display("FAIL midrst_async_in got %h exp 00", {mul_in1, mul_in2}); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({bus.res0_valid, bus.res1_valid, bus.res_pro} !== 10'h000) begin errors++; $display("FAIL midrst_res%0d got %b%b/%h exp 00/00", i, bus.res0_valid, bus.res1_valid, bus.res_pro); end
        end
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL midrst_first_grant got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
        bus.req0_valid = 0; bus.req1_valid = 0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_alternate();
        test_backpressure();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one combinational `WIDTH`×`WIDTH` multiplier (`mul`) between two requesters. It accepts operand pairs over valid/ready handshakes and registers them onto the multiplier inputs. It captures the product one cycle later and returns it to the granted requester over a result valid/ready handshake. It sits between two client blocks and the single `mul` instance, which is wired externally through the `mul_*` ports.

## Interface
- `WIDTH`, default 4: operand width; product width is 2*`WIDTH`.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  requester has an operand pair.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  `WIDTH`  operands.
- `req0_ready`, `req1_ready`  out  1  operand pair accepted this cycle when valid&&ready.
- `res0_valid`, `res1_valid`  out  1  product available for that requester.
- `res0_ready`, `res1_ready`  in  1  requester consumes product.
- `res_pro`  out  2*`WIDTH`  product (shared bus, qualified by `resN_valid`).
- `mul_in1`, `mul_in2`  out  `WIDTH`  to multiplier `in1`/`in2`.
- `mul_pro`  in  2*`WIDTH`  from multiplier `pro`.

## Operation
- States: IDLE, EXEC, RESP; 2-bit state register.
- IDLE: the grant is computed combinationally from `req*_valid` and `last` (1-bit pointer to the last granted requester).
  - Only one valid: grant it.
  - Both valid: grant the requester != `last`.
  - `reqN_ready` = (state==IDLE) && grant==N. At most one ready is high; none when no request is valid.
  - On handshake: latch `reqN_a` into `op_a` and `reqN_b` into `op_b`, store `gnt`=N, update `last`=N, go to EXEC.
- EXEC: `mul_in1`=`op_a` and `mul_in2`=`op_b` have been stable since the cycle edge. Capture `mul_pro` into `pro_q`, go to RESP.
- RESP: `res_pro`=`pro_q` and `res{gnt}_valid`=1.
  - On `res{gnt}_ready`=1: go to IDLE.
  - Otherwise hold, with `res_pro` and `res_valid` stable.
  - The non-granted `res_ready` is ignored.
- No new request is accepted outside IDLE; `reqN_ready`=0 in EXEC and RESP.
- Arithmetic: unsigned. The product is the full 2*`WIDTH` bits with no truncation. Maximum is 0xF*0xF=0xE1 for `WIDTH`=4.
- `mul_in1` and `mul_in2` are driven continuously from `op_a` and `op_b`; their values persist through IDLE.

## Timing
- Reset values:
  - state=IDLE, `last`=1 (req0 wins the first contention), `gnt`=0.
  - `op_a`=`op_b`=0, `pro_q`=0.
  - All `res*_valid`=0 and `res_pro`=0.
  - `reqN_ready` is 0 unless the request is valid.
- Latency: handshake at edge T; EXEC during cycle T+1; `resN_valid` high in cycle T+2.
- Throughput: a minimum of 3 cycles per operation, when `res_ready` is held high.
- Back-to-back: when the result completes at edge T+3, a pending request can handshake in cycle T+3.
- Simultaneous valid on both: arbitration alternates strictly per grant.
- Valid dropped before ready: no transfer, no state change. Valid must be held until ready.
- Reset mid-operation (EXEC or RESP): the operation is abandoned and no result is delivered. Everything returns to reset values asynchronously.

## Configuration
- `MUL_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; req0 always wins when both are valid. The `last` register is still updated but ignored.
  - Undefined (default): round-robin as described above.

## Test plan
- Single requester: req0 a=3, b=7 -> `req0_ready` in the same cycle; `res0_valid`=1 two cycles later with `res_pro`=0x15; `res1_valid` stays 0.
- Contention: both valid after reset, req0 3*5 and req1 0xE*0xB -> req0 served first with 0x0F, then req1 with 0x9A. A second simultaneous pair is served req0 then req1 again, since `last`=1 after req1.
- Backpressure: `res1_ready`=0 for 5 cycles on 0xC*0xD -> `res1_valid` and `res_pro`=0x9C stay stable; `req*_ready`=0 throughout; release -> IDLE next cycle.
- Boundaries: 0*5 -> 0x00; 0xF*0xF -> 0xE1; 1*0xD -> 0x0D.
- Reset asserted in EXEC -> no `res*_valid` pulse; after release, all outputs are at reset values and req0 wins the next contention.
- With `MUL_ARB_FIXED_PRIO_EN` defined: both requesters held valid continuously -> req0 granted every time and req1 starves. Dropping `req0_valid` -> req1 granted.
